// File: rtl/byte_lane_unit.sv
// Two-stage valid/ready lane-manipulation unit (insert, fill, reverse, sign-extend) on DATA_W in LANE_W lanes.
// Optional BYTE_LANE_STATS_EN adds saturating consumed-result / error-result counters.
module byte_lane_unit #(
    parameter int DATA_W = 16,
    parameter int LANE_W = 8,
    parameter int LSEL_W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [LSEL_W-1:0] lane_sel,
    input  logic [DATA_W-1:0] dst_in,
    input  logic [LANE_W-1:0] byte_val,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] dst_out,
    output logic              out_z,
    output logic              out_n,
    output logic              out_err
`ifdef BYTE_LANE_STATS_EN
    ,
    output logic [15:0]       stat_ops,
    output logic [15:0]       stat_errs
`endif
);

    localparam int          NUM_LANES   = DATA_W / LANE_W;
    localparam logic [31:0] NUM_LANES_U = NUM_LANES;

    typedef enum logic [3:0] {
        OP_MOVL  = 4'd0,
        OP_MOVLZ = 4'd1,
        OP_MOVLS = 4'd2,
        OP_MOVH  = 4'd3,
        OP_SWPB  = 4'd4,
        OP_SXT   = 4'd5,
        OP_MOVLN = 4'd6,
        OP_CLRLN = 4'd7
    } op_e;

    logic              s1_valid_q, s1_valid_d;
    logic [3:0]        s1_op_q, s1_op_d;
    logic [LSEL_W-1:0] s1_lsel_q, s1_lsel_d;
    logic [DATA_W-1:0] s1_dst_q, s1_dst_d;
    logic [LANE_W-1:0] s1_byte_q, s1_byte_d;

    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] s2_dst_q, s2_dst_d;
    logic              s2_z_q, s2_z_d;
    logic              s2_n_q, s2_n_d;
    logic              s2_err_q, s2_err_d;

    logic              s2_adv;
    logic              s1_adv;
    logic              accept;
    logic              lsel_ok;
    logic [DATA_W-1:0] res;
    logic              res_err;

    always_comb begin
        s2_adv   = !s2_valid_q || out_ready;
        s1_adv   = s1_valid_q && s2_adv;
        in_ready = !flush && (!s1_valid_q || s1_adv);
        accept   = in_valid && in_ready;
    end

    // Result of the op held in stage 1; error results pass the destination through.
    always_comb begin
        res     = s1_dst_q;
        res_err = 1'b0;
        lsel_ok = 32'(s1_lsel_q) < NUM_LANES_U;
        case (s1_op_q)
            OP_MOVL: res[LANE_W-1:0] = s1_byte_q;
            OP_MOVLZ: begin
                res = '0;
                res[LANE_W-1:0] = s1_byte_q;
            end
            OP_MOVLS: begin
                res = '1;
                res[LANE_W-1:0] = s1_byte_q;
            end
            OP_MOVH: res[DATA_W-1 -: LANE_W] = s1_byte_q;
            OP_SWPB: begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    res[i*LANE_W +: LANE_W] = s1_dst_q[(NUM_LANES-1-i)*LANE_W +: LANE_W];
                end
            end
            OP_SXT: begin
                res = {DATA_W{s1_dst_q[LANE_W-1]}};
                res[LANE_W-1:0] = s1_dst_q[LANE_W-1:0];
            end
            OP_MOVLN, OP_CLRLN: begin
                if (lsel_ok) begin
                    for (int i = 0; i < NUM_LANES; i++) begin
                        if (LSEL_W'(i) == s1_lsel_q) begin
                            res[i*LANE_W +: LANE_W] = (s1_op_q == OP_MOVLN) ? s1_byte_q : '0;
                        end
                    end
                end else begin
                    res_err = 1'b1;
                end
            end
            default: res_err = 1'b1;
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_lsel_d  = s1_lsel_q;
        s1_dst_d   = s1_dst_q;
        s1_byte_d  = s1_byte_q;
        s2_valid_d = s2_valid_q;
        s2_dst_d   = s2_dst_q;
        s2_z_d     = s2_z_q;
        s2_n_d     = s2_n_q;
        s2_err_d   = s2_err_q;

        if (accept) begin
            s1_op_d   = op;
            s1_lsel_d = lane_sel;
            s1_dst_d  = dst_in;
            s1_byte_d = byte_val;
        end

        if (s1_adv) begin
            s2_dst_d = res;
            s2_z_d   = (res == '0);
            s2_n_d   = res[DATA_W-1];
            s2_err_d = res_err;
        end

        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (accept)      s1_valid_d = 1'b1;
            else if (s1_adv) s1_valid_d = 1'b0;
            if (s2_adv)      s2_valid_d = s1_valid_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_lsel_q  <= '0;
            s1_dst_q   <= '0;
            s1_byte_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_dst_q   <= '0;
            s2_z_q     <= 1'b0;
            s2_n_q     <= 1'b0;
            s2_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_lsel_q  <= s1_lsel_d;
            s1_dst_q   <= s1_dst_d;
            s1_byte_q  <= s1_byte_d;
            s2_valid_q <= s2_valid_d;
            s2_dst_q   <= s2_dst_d;
            s2_z_q     <= s2_z_d;
            s2_n_q     <= s2_n_d;
            s2_err_q   <= s2_err_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign dst_out   = s2_dst_q;
    assign out_z     = s2_z_q;
    assign out_n     = s2_n_q;
    assign out_err   = s2_err_q;

`ifdef BYTE_LANE_STATS_EN
    logic [15:0] stat_ops_q, stat_ops_d;
    logic [15:0] stat_errs_q, stat_errs_d;
    logic        consumed;

    always_comb begin
        consumed    = s2_valid_q && out_ready && !flush;
        stat_ops_d  = stat_ops_q;
        stat_errs_d = stat_errs_q;
        if (flush) begin
            stat_ops_d  = '0;
            stat_errs_d = '0;
        end else if (consumed) begin
            if (stat_ops_q != 16'hFFFF)              stat_ops_d  = stat_ops_q + 16'd1;
            if (s2_err_q && stat_errs_q != 16'hFFFF) stat_errs_d = stat_errs_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops_q  <= '0;
            stat_errs_q <= '0;
        end else begin
            stat_ops_q  <= stat_ops_d;
            stat_errs_q <= stat_errs_d;
        end
    end

    assign stat_ops  = stat_ops_q;
    assign stat_errs = stat_errs_q;
`endif

endmodule

// File: doc/byte_lane_unit.md
Name: byte_lane_unit

Overview:
- Parametrised, pipelined successor to the single-width byte-manipulation unit.
- Executes lane-insert, zero/sign fill, lane-reverse and sign-extend ops on a DATA_W register value, in LANE_W-bit lanes.
- Sits between operand fetch and register write-back in the execute stage.
- Two-stage valid/ready pipeline with full backpressure; one op per cycle sustained.

Parameters:
- DATA_W, 16: register width; must be an integer multiple of LANE_W.
- LANE_W, 8: lane width; NUM_LANES = DATA_W/LANE_W, must be >= 2.
- LSEL_W, 1: lane-select width; must be >= clog2(NUM_LANES) and >= 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset: one clock; reset is asynchronous and active-low.
- flush  in  1  synchronous pipeline clear; in-flight ops are discarded.
- in_valid  in  1  op present on the input.
- in_ready  out  1  unit accepts the op this cycle.
- op  in  4  operation code (see Behaviour).
- lane_sel  in  LSEL_W  target lane for MOVLN/CLRLN.
- dst_in  in  DATA_W  current destination value.
- byte_val  in  LANE_W  immediate lane value.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result.
- dst_out  out  DATA_W  result.
- out_z  out  1  dst_out == 0.
- out_n  out  1  dst_out[DATA_W-1].
- out_err  out  1  illegal op or out-of-range lane_sel.

Behaviour:
- Reset (async, rst_n low): s1_valid = 0, s2_valid = 0, out_valid = 0, dst_out = 0, out_z = 0, out_n = 0, out_err = 0. in_ready is 1 on the first cycle after rst_n rises.
- Handshake: an op is accepted when in_valid && in_ready. A result is consumed when out_valid && out_ready. out_valid, dst_out and flags hold stable while out_valid && !out_ready.
- Stage 1 captures op, lane_sel, dst_in and byte_val on accept.
- Stage 2 computes the result from the stage-1 registers and registers it. All ops use the captured values of that same op; there is no stale-value dependence.
- Latency: accept at edge N gives out_valid at edge N+2.
- s2 advance: !s2_valid || out_ready.
- s1 advance: s1_valid && s2 advance.
- in_ready = !s1_valid || s1 advance, so throughput is 1 op/cycle with out_ready held high.
- Ops (L0 = lane 0, LT = top lane):
  - 0 MOVL: L0 = byte_val; other lanes kept.
  - 1 MOVLZ: L0 = byte_val; other lanes 0.
  - 2 MOVLS: L0 = byte_val; other lanes all 1.
  - 3 MOVH: LT = byte_val; other lanes kept.
  - 4 SWPB: lane order reversed (16/8 case swaps bytes); byte_val ignored.
  - 5 SXT: upper lanes = replicate dst_in[LANE_W-1]; L0 kept.
  - 6 MOVLN: lane[lane_sel] = byte_val; other lanes kept.
  - 7 CLRLN: lane[lane_sel] = 0; other lanes kept.
  - 8-15: illegal.
- Errors: for an illegal op, or MOVLN/CLRLN with lane_sel >= NUM_LANES, dst_out = dst_in unchanged and out_err = 1. Otherwise out_err = 0.
- Flags out_z and out_n are computed from the final dst_out, including error results.
- flush: at the next edge s1_valid = 0 and s2_valid = 0. An op offered in the same cycle as flush is not accepted (in_ready = 0 while flush = 1). flush overrides out_ready.
- Reset mid-operation: all in-flight ops are lost; there is no partial output.

Optional Feature:
- Macro BYTE_LANE_STATS_EN.
- Defined: adds output ports stat_ops[15:0] and stat_errs[15:0]. stat_ops increments on each consumed result; stat_errs increments on each consumed result with out_err = 1. Both saturate at 16'hFFFF and are cleared by reset and by flush.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Defaults; op=0, dst_in=16'h1234, byte_val=8'hAB, out_ready=1 -> 2 cycles later dst_out=16'h12AB, out_z=0, out_n=0, out_err=0.
- op=1 then op=2 back-to-back, dst_in=16'h1234, byte_val=8'h80 -> consecutive cycles dst_out=16'h0080, then 16'hFF80 with out_n=1.
- op=4, dst_in=16'h1234 -> 16'h3412. op=5, dst_in=16'h00F0 -> 16'hFFF0, out_n=1. op=3, dst_in=16'h1234, byte_val=8'h00 -> 16'h0034.
- DATA_W=32: op=6, lane_sel=2, dst_in=32'h11223344, byte_val=8'hEE -> 32'h11EE3344. op=7, lane_sel=0, dst_in=32'h000000FF -> 0, out_z=1.
- Backpressure: 4 ops streamed with out_ready=0 -> in_ready drops after 2 accepts and dst_out is held stable. Raise out_ready -> results emerge in order with none lost or duplicated.
- op=9, dst_in=16'h5A5A -> dst_out=16'h5A5A, out_err=1. flush asserted with 2 ops in flight -> out_valid=0 next cycle. With BYTE_LANE_STATS_EN, stat_errs=1 before the flush and 0 after it.
